// File: rtl/aes_inv_key_schedule.sv
// rtl/aes_inv_key_schedule.sv - AES-128 reverse round-key generator, round 10 down to 0
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] s
);

  logic [7:0] sq;
  logic [7:0] inv;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine transform
  always_comb begin
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] last_key,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [0:127] round_key,
  output logic [3:0]   rk_round,
  output logic         rk_last
);

  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;

  logic [0:31]  w0, w1, w2, w3;
  logic [0:31]  v0, v1, v2, v3;
  logic [0:31]  rot, sub;
  logic [7:0]   rcon;
  logic [0:127] prev_key;

  assign w0 = round_key[0:31];
  assign w1 = round_key[32:63];
  assign w2 = round_key[64:95];
  assign w3 = round_key[96:127];

  assign v3  = w3 ^ w2;
  assign v2  = w2 ^ w1;
  assign v1  = w1 ^ w0;
  assign rot = {v3[8:31], v3[0:7]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (
      .x (rot[8*i +: 8]),
      .s (sub[8*i +: 8])
    );
  end

  always_comb begin
    rcon = 8'h00;
    case (rk_round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign v0       = w0 ^ sub ^ {rcon, 24'h000000};
  assign prev_key = {v0, v1, v2, v3};

  // All outputs are registers, so rk_ready only ever reaches them through a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_key <= '0;
      rk_round  <= 4'd0;
      rk_valid  <= 1'b0;
      rk_last   <= 1'b0;
      key_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            state     <= EMIT;
            round_key <= last_key;
            rk_round  <= 4'd10;
            rk_valid  <= 1'b1;
            rk_last   <= 1'b0;
            key_ready <= 1'b0;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (rk_round == 4'd0) begin
              state     <= IDLE;
              rk_valid  <= 1'b0;
              rk_last   <= 1'b0;
              key_ready <= 1'b1;
            end else begin
              round_key <= prev_key;
              rk_round  <= rk_round - 4'd1;
              rk_last   <= (rk_round == 4'd1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          rk_valid  <= 1'b0;
          rk_last   <= 1'b0;
          key_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb/tb_aes_inv_key_schedule.sv - random and directed checks against a forward key-expansion model
module tb_aes_inv_key_schedule;

  logic         clk;
  logic         rst;
  logic [0:127] last_key;
  logic         key_valid;
  logic         key_ready;
  logic         rk_ready;
  logic         rk_valid;
  logic [0:127] round_key;
  logic [3:0]   rk_round;
  logic         rk_last;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [127:0] ZERO_LAST = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9   = 128'hac7766f319fadc2128d12941575c006e;

  aes_inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .last_key  (last_key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_ready  (rk_ready),
    .rk_valid  (rk_valid),
    .round_key (round_key),
    .rk_round  (rk_round),
    .rk_last   (rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Forward FIPS-197 expansion of the cipher key; exp_rk[n] is round key n
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n <= 10; n++) exp_rk[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endtask

  task automatic load_key(input string tag, input logic [127:0] k);
    int guard;
    guard = 0;
    while (!key_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("%s_key_ready", tag), key_ready, 1);
    key_valid = 1'b1;
    last_key  = k;
    @(negedge clk);
    key_valid = 1'b0;
    last_key  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called at the negedge where rk_round=10 should already be presented
  task automatic collect(input string tag, input bit bp, input bit kv_noise, input int abort_at,
                         input bit chain, input logic [127:0] chain_key);
    int r;
    int cycles;
    bit rdy;
    r = 10;
    cycles = 0;
    while (r >= 0) begin
      if (cycles >= 300) begin
        check($sformatf("%s_timeout_rounds_left", tag), 128'(r), 128'(-1));
        break;
      end
      check($sformatf("%s_valid_r%0d", tag, r), rk_valid, 1);
      check($sformatf("%s_key_r%0d", tag, r), round_key, exp_rk[r]);
      check($sformatf("%s_round_r%0d", tag, r), 128'(rk_round), 128'(r));
      check($sformatf("%s_last_r%0d", tag, r), rk_last, (r == 0));
      check($sformatf("%s_kready_r%0d", tag, r), key_ready, 0);
      if (abort_at == r) begin
        rst       = 1'b1;
        rk_ready  = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check($sformatf("%s_abort_valid", tag), rk_valid, 0);
        check($sformatf("%s_abort_kready", tag), key_ready, 1);
        check($sformatf("%s_abort_last", tag), rk_last, 0);
        check($sformatf("%s_abort_round", tag), 128'(rk_round), 0);
        check($sformatf("%s_abort_key", tag), round_key, 0);
        @(negedge clk);
        check($sformatf("%s_abort_quiet", tag), rk_valid, 0);
        return;
      end
      rdy = (chain && r == 0) ? 1'b1 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      rk_ready = rdy;
      if (kv_noise) begin
        key_valid = 1'($urandom_range(0, 1));
        last_key  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (chain && r == 0) begin
        key_valid = 1'b1;
        last_key  = chain_key;
      end
      if (rdy) got_rk[r] = round_key;
      @(negedge clk);
      cycles++;
      if (rdy) r--;
    end
    rk_ready = 1'b0;
    if (!chain) key_valid = 1'b0;
    check($sformatf("%s_idle_valid", tag), rk_valid, 0);
    check($sformatf("%s_idle_kready", tag), key_ready, 1);
    check($sformatf("%s_idle_last", tag), rk_last, 0);
  endtask

  initial begin
    logic [127:0] base;
    rst       = 1'b1;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    last_key  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_valid", rk_valid, 0);
    check("reset_kready", key_ready, 1);
    check("reset_last", rk_last, 0);
    check("reset_round", 128'(rk_round), 0);
    check("reset_key", round_key, 0);

    expand(128'h0);
    load_key("zero", ZERO_LAST);
    collect("zero", 0, 0, -1, 0, '0);
    check("zero_r0_direct", got_rk[0], 128'h0);

    expand(FIPS_KEY);
    load_key("fips", FIPS_LAST);
    collect("fips", 0, 0, -1, 0, '0);
    check("fips_r9_direct", got_rk[9], FIPS_R9);
    check("fips_r0_direct", got_rk[0], FIPS_KEY);

    expand(128'h0);
    load_key("bp", ZERO_LAST);
    collect("bp", 1, 0, -1, 0, '0);

    expand(FIPS_KEY);
    load_key("kvnoise", FIPS_LAST);
    collect("kvnoise", 1, 1, -1, 0, '0);

    expand(128'h0);
    load_key("rst5", ZERO_LAST);
    collect("rst5", 0, 0, 5, 0, '0);
    load_key("reload", ZERO_LAST);
    collect("reload", 0, 0, -1, 0, '0);

    expand(FIPS_KEY);
    load_key("b2b_a", FIPS_LAST);
    collect("b2b_a", 0, 0, -1, 1, ZERO_LAST);
    @(negedge clk);
    key_valid = 1'b0;
    expand(128'h0);
    collect("b2b_b", 0, 0, -1, 0, '0);

    for (int k = 0; k < 6; k++) begin
      base = {$urandom, $urandom, $urandom, $urandom};
      expand(base);
      load_key($sformatf("rand%0d", k), exp_rk[10]);
      collect($sformatf("rand%0d", k), 1'(k % 2), 1'(k / 3), -1, 0, '0);
      check($sformatf("rand%0d_r0_base", k), got_rk[0], base);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
